eth_rx_fcs_check: RTL and testbench

Receive-path stage directly downstream of the GMII receiver. It consumes that receiver's local-clock byte stream (sof / eof / valid / data) and delays the stream by 4 bytes so the FCS can be stripped. It checks the Ethernet CRC-32 and frame length, then re-emits the frame without its FCS. A per-frame status is issued with eof_out to the MAC-layer frame buffer.

---
 rtl/ethernet_pkg.sv | 32 +++
 rtl/eth_rx_fcs_check.sv | 182 ++++++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_pkg.sv
// Shared Ethernet receive-path definitions: CRC-32 constants, error flag
// layout and a byte-wide CRC-32 next-state function.
package ethernet_pkg;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef struct packed {
        logic abort;
        logic giant;
        logic runt;
        logic crc;
    } rx_err_flags_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_t;

    // Reflected CRC-32, one byte per call, data consumed LSB first.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: delays the GMII byte stream by 4 bytes to strip the FCS,
// checks CRC-32 and length, and reports per-frame status with eof_out.
// Optional statistics counters are enabled by defining RX_FCS_STATS_EN.
module eth_rx_fcs_check
    import ethernet_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                 lcl_clk,
    input  logic                 reset_n,
    input  logic                 sof_in,
    input  logic                 eof_in,
    input  logic                 valid_in,
    input  logic [7:0]           data_in,
    output logic                 sof_out,
    output logic                 valid_out,
    output logic [7:0]           data_out,
    output logic                 eof_out,
    output logic                 frame_good,
    output logic [3:0]           err_flags,
    output logic [LEN_WIDTH-1:0] frame_len
`ifdef RX_FCS_STATS_EN
    ,
    input  logic                 clear_stats,
    output logic [31:0]          good_frames,
    output logic [31:0]          crc_err_frames,
    output logic [31:0]          len_err_frames,
    output logic [31:0]          abort_frames
`endif
);

    localparam logic [LEN_WIDTH-1:0] L_MIN = LEN_WIDTH'(MIN_FRAME_LEN);
    localparam logic [LEN_WIDTH-1:0] L_MAX = LEN_WIDTH'(MAX_FRAME_LEN);

    rx_state_t            r_state;
    logic [31:0]          r_crc;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [2:0]           r_fill;
    logic [7:0]           r_dly [0:3];
    logic                 r_sof_pend;
    logic                 r_sof_out;
    logic                 r_valid_out;
    logic [7:0]           r_data_out;
    logic                 r_eof_out;
    logic                 r_good;
    rx_err_flags_t        r_flags;
    logic [LEN_WIDTH-1:0] r_len;

    logic                 w_in_frame;
    logic                 w_push;
    logic                 w_close;
    logic [31:0]          w_crc_next;
    logic [LEN_WIDTH-1:0] w_cnt_next;
    rx_err_flags_t        w_flags;

    assign w_in_frame = (r_state == ST_FRAME);
    assign w_push     = w_in_frame & valid_in;
    assign w_close    = w_in_frame & (eof_in | sof_in);
    assign w_crc_next = w_push ? crc32_d8(r_crc, data_in) : r_crc;
    assign w_cnt_next = (w_push && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

    // A sof_in without a coincident eof_in truncates the running frame.
    always_comb begin
        w_flags       = '0;
        w_flags.abort = sof_in & ~eof_in;
        w_flags.giant = (w_cnt_next > L_MAX);
        w_flags.runt  = (w_cnt_next < L_MIN);
        w_flags.crc   = (w_crc_next != CRC32_RESIDUE);
    end

    always_ff @(posedge lcl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_crc       <= CRC32_INIT;
            r_cnt       <= '0;
            r_fill      <= 3'd0;
            r_sof_pend  <= 1'b0;
            r_sof_out   <= 1'b0;
            r_valid_out <= 1'b0;
            r_data_out  <= 8'h00;
            r_eof_out   <= 1'b0;
            r_good      <= 1'b0;
            r_flags     <= '0;
            r_len       <= '0;
        end else begin
            r_sof_out   <= r_sof_pend;
            r_sof_pend  <= 1'b0;
            r_valid_out <= 1'b0;
            r_eof_out   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sof_in) begin
                        r_state   <= ST_FRAME;
                        r_sof_out <= 1'b1;
                        r_crc     <= CRC32_INIT;
                        r_cnt     <= '0;
                        r_fill    <= 3'd0;
                    end
                end
                ST_FRAME: begin
                    if (w_close) begin
                        r_eof_out <= 1'b1;
                        r_good    <= ~|w_flags;
                        r_flags   <= w_flags;
                        r_len     <= w_cnt_next;
                        r_crc     <= CRC32_INIT;
                        r_cnt     <= '0;
                        r_fill    <= 3'd0;
                        // Restart: sof_out trails eof_out by one cycle.
                        if (sof_in) begin
                            r_sof_pend <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (valid_in) begin
                        r_crc <= w_crc_next;
                        r_cnt <= w_cnt_next;
                        if (r_fill == 3'd4) begin
                            r_valid_out <= 1'b1;
                            r_data_out  <= r_dly[3];
                        end else begin
                            r_fill <= r_fill + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shift register; once full, entry 3 holds the oldest byte.
    always_ff @(posedge lcl_clk) begin
        if (w_push && !w_close) begin
            r_dly[0] <= data_in;
            for (int i = 1; i < 4; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign sof_out    = r_sof_out;
    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign eof_out    = r_eof_out;
    assign frame_good = r_good;
    assign err_flags  = r_flags;
    assign frame_len  = r_len;

`ifdef RX_FCS_STATS_EN
    logic [31:0] r_good_frames;
    logic [31:0] r_crc_err_frames;
    logic [31:0] r_len_err_frames;
    logic [31:0] r_abort_frames;

    always_ff @(posedge lcl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_good_frames    <= '0;
            r_crc_err_frames <= '0;
            r_len_err_frames <= '0;
            r_abort_frames   <= '0;
        end else if (clear_stats) begin
            r_good_frames    <= '0;
            r_crc_err_frames <= '0;
            r_len_err_frames <= '0;
            r_abort_frames   <= '0;
        end else if (r_eof_out) begin
            if (r_good)                       r_good_frames    <= r_good_frames + 32'd1;
            if (r_flags.crc)                  r_crc_err_frames <= r_crc_err_frames + 32'd1;
            if (r_flags.runt | r_flags.giant) r_len_err_frames <= r_len_err_frames + 32'd1;
            if (r_flags.abort)                r_abort_frames   <= r_abort_frames + 32'd1;
        end
    end

    assign good_frames    = r_good_frames;
    assign crc_err_frames = r_crc_err_frames;
    assign len_err_frames = r_len_err_frames;
    assign abort_frames   = r_abort_frames;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed self-checking bench for eth_rx_fcs_check (stats checks included
// when RX_FCS_STATS_EN is defined).
module tb_eth_rx_fcs_check;

    localparam int LW = 16;

    logic          lcl_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sof_in = 1'b0, eof_in = 1'b0, valid_in = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          sof_out, valid_out, eof_out, frame_good;
    logic [7:0]    data_out;
    logic [3:0]    err_flags;
    logic [LW-1:0] frame_len;
`ifdef RX_FCS_STATS_EN
    logic          clear_stats = 1'b0;
    logic [31:0]   good_frames, crc_err_frames, len_err_frames, abort_frames;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]    frm[$];
    logic [7:0]    a_bytes[$];
    logic [7:0]    out_q[$];
    int            out_cyc[$], in_cyc[$], sof_cyc[$], eof_cyc[$];
    logic [3:0]    eflags_q[$];
    logic          egood_q[$];
    logic [LW-1:0] elen_q[$];

    eth_rx_fcs_check #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .LEN_WIDTH(LW)) dut (
        .lcl_clk   (lcl_clk),
        .reset_n   (reset_n),
        .sof_in    (sof_in),
        .eof_in    (eof_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sof_out   (sof_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .eof_out   (eof_out),
        .frame_good(frame_good),
        .err_flags (err_flags),
        .frame_len (frame_len)
`ifdef RX_FCS_STATS_EN
        ,
        .clear_stats   (clear_stats),
        .good_frames   (good_frames),
        .crc_err_frames(crc_err_frames),
        .len_err_frames(len_err_frames),
        .abort_frames  (abort_frames)
`endif
    );

    always #4 lcl_clk = ~lcl_clk;

    always @(posedge lcl_clk) cyc++;

    always @(negedge lcl_clk) begin
        if (valid_out) begin
            out_q.push_back(data_out);
            out_cyc.push_back(cyc);
        end
        if (sof_out) sof_cyc.push_back(cyc);
        if (eof_out) begin
            eof_cyc.push_back(cyc);
            eflags_q.push_back(err_flags);
            egood_q.push_back(frame_good);
            elen_q.push_back(frame_len);
        end
    end

    // Bit-serial reference CRC over frm[0..n-1].
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build_good(input int n, input int seed);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'(i * seed + 3));
        c = ~model_crc(n - 4);
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic clear_mon();
        out_q.delete(); out_cyc.delete(); in_cyc.delete();
        sof_cyc.delete(); eof_cyc.delete();
        eflags_q.delete(); egood_q.delete(); elen_q.delete();
    endtask

    task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] d);
        @(posedge lcl_clk);
        #1;
        sof_in = s; eof_in = e; valid_in = v; data_in = d;
        if (v) in_cyc.push_back(cyc);
    endtask

    task automatic send_body(input bit gap);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b0, 1'b0, 1'b1, frm[i]);
            if (gap) drive(1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic send_frame(input bit gap);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_body(gap);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_eof(input int n, input string name);
        int k;
        k = 0;
        while (eof_cyc.size() < n && k < 50) begin
            @(posedge lcl_clk);
            k++;
        end
        @(negedge lcl_clk);
        #1;
        total++;
        if (eof_cyc.size() < n) begin
            bad++;
            $display("FAIL %s_eof_timeout: got %0d eof_out, need %0d", name, eof_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge lcl_clk);
        #1;
        total++;
        if ({sof_out, valid_out, eof_out, frame_good} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got %b need 0000", {sof_out, valid_out, eof_out, frame_good});
        end
        total++;
        if (err_flags !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b need 0000", err_flags);
        end
        total++;
        if (frame_len !== '0) begin
            bad++; $display("FAIL reset_len: got %0d need 0", frame_len);
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h need 00", data_out);
        end
        reset_n = 1'b1;
        $display("reset: checked outputs 0");
    endtask

    task automatic test_good64();
        int mism;
        build_good(64, 5);
        clear_mon();
        send_frame(1'b0);
        wait_eof(1, "good64");
        total++;
        if (out_q.size() !== 60) begin
            bad++; $display("FAIL good64_count: got %0d need 60", out_q.size());
        end
        mism = 0;
        for (int j = 0; j < out_q.size() && j < 60; j++) if (out_q[j] !== frm[j]) mism++;
        total++;
        if (mism !== 0) begin
            bad++; $display("FAIL good64_data: got %0d mismatching bytes need 0", mism);
        end
        if (eof_cyc.size() == 1) begin
            total++;
            if (eflags_q[0] !== 4'b0000 || egood_q[0] !== 1'b1) begin
                bad++; $display("FAIL good64_status: got flags=%b good=%b need 0000/1", eflags_q[0], egood_q[0]);
            end
            total++;
            if (elen_q[0] !== 16'd64) begin
                bad++; $display("FAIL good64_len: got %0d need 64", elen_q[0]);
            end
        end
        total++;
        if (sof_cyc.size() !== 1 || out_q.size() == 0 || sof_cyc[0] >= out_cyc[0]) begin
            bad++; $display("FAIL good64_sof: got %0d sof_out pulses (or sof not before data) need 1", sof_cyc.size());
        end
        $display("good64: %0d bytes out", out_q.size());
    endtask

    task automatic test_crc_err();
        build_good(64, 5);
        frm[10] = frm[10] ^ 8'h01;
        clear_mon();
        send_frame(1'b0);
        wait_eof(1, "crcerr");
        total++;
        if (out_q.size() !== 60) begin
            bad++; $display("FAIL crcerr_count: got %0d need 60", out_q.size());
        end
        if (eof_cyc.size() == 1) begin
            total++;
            if (eflags_q[0] !== 4'b0001 || egood_q[0] !== 1'b0) begin
                bad++; $display("FAIL crcerr_status: got flags=%b good=%b need 0001/0", eflags_q[0], egood_q[0]);
            end
        end
        $display("crcerr: %0d bytes out", out_q.size());
    endtask

    task automatic test_length(input int n, input logic [3:0] exp_flags, input string name);
        build_good(n, 3);
        clear_mon();
        send_frame(1'b0);
        wait_eof(1, name);
        total++;
        if (out_q.size() !== n - 4) begin
            bad++; $display("FAIL %s_count: got %0d need %0d", name, out_q.size(), n - 4);
        end
        if (eof_cyc.size() == 1) begin
            total++;
            if (eflags_q[0] !== exp_flags || egood_q[0] !== (exp_flags == 4'b0000)) begin
                bad++; $display("FAIL %s_status: got flags=%b good=%b need %b", name, eflags_q[0], egood_q[0], exp_flags);
            end
            total++;
            if (elen_q[0] !== LW'(n)) begin
                bad++; $display("FAIL %s_len: got %0d need %0d", name, elen_q[0], n);
            end
        end
        $display("%s: len %0d, %0d bytes out", name, n, out_q.size());
    endtask

    task automatic test_empty();
        clear_mon();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        wait_eof(1, "empty");
        total++;
        if (out_q.size() !== 0 || sof_cyc.size() !== 1) begin
            bad++; $display("FAIL empty_io: got %0d bytes %0d sof need 0/1", out_q.size(), sof_cyc.size());
        end
        if (eof_cyc.size() == 1) begin
            total++;
            if (eflags_q[0] !== 4'b0011 || elen_q[0] !== '0) begin
                bad++; $display("FAIL empty_status: got flags=%b len=%0d need 0011/0", eflags_q[0], elen_q[0]);
            end
        end
        $display("empty: flags checked");
    endtask

    task automatic test_gaps();
        int mism, tmis;
        build_good(100, 11);
        clear_mon();
        send_frame(1'b1);
        wait_eof(1, "gaps");
        total++;
        if (out_q.size() !== 96) begin
            bad++; $display("FAIL gaps_count: got %0d need 96", out_q.size());
        end
        mism = 0;
        tmis = 0;
        for (int j = 0; j < out_q.size() && j < 96; j++) begin
            if (out_q[j] !== frm[j]) mism++;
            if (out_cyc[j] !== in_cyc[j + 4] + 1) tmis++;
        end
        total++;
        if (mism !== 0) begin
            bad++; $display("FAIL gaps_data: got %0d mismatching bytes need 0", mism);
        end
        total++;
        if (tmis !== 0) begin
            bad++; $display("FAIL gaps_timing: got %0d late/early bytes need 0", tmis);
        end
        if (eof_cyc.size() == 1) begin
            total++;
            if (egood_q[0] !== 1'b1) begin
                bad++; $display("FAIL gaps_good: got %b need 1", egood_q[0]);
            end
        end
        $display("gaps: %0d bytes out", out_q.size());
    endtask

    task automatic test_abort();
        logic        a_crc;
        int          mism;
        logic [3:0]  exp_a;
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'(i * 7 + 1));
        a_crc = (model_crc(20) != 32'hDEBB20E3);
        exp_a = {1'b1, 1'b0, 1'b1, a_crc};
        a_bytes = frm;
        clear_mon();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_body(1'b0);
        build_good(64, 9);
        send_frame(1'b0);
        wait_eof(2, "abort");
        if (eof_cyc.size() == 2) begin
            total++;
            if (eflags_q[0] !== exp_a || egood_q[0] !== 1'b0) begin
                bad++; $display("FAIL abortA_status: got flags=%b good=%b need %b/0", eflags_q[0], egood_q[0], exp_a);
            end
            total++;
            if (elen_q[0] !== 16'd20) begin
                bad++; $display("FAIL abortA_len: got %0d need 20", elen_q[0]);
            end
            total++;
            if (eflags_q[1] !== 4'b0000 || egood_q[1] !== 1'b1) begin
                bad++; $display("FAIL abortB_status: got flags=%b good=%b need 0000/1", eflags_q[1], egood_q[1]);
            end
            total++;
            if (sof_cyc.size() !== 2 || sof_cyc[1] !== eof_cyc[0] + 1) begin
                bad++; $display("FAIL abort_sof_order: got %0d sof pulses, need 2 with B sof one cycle after A eof", sof_cyc.size());
            end
        end
        total++;
        if (out_q.size() !== 76) begin
            bad++; $display("FAIL abort_count: got %0d need 76", out_q.size());
        end
        mism = 0;
        for (int j = 0; j < out_q.size() && j < 76; j++) begin
            if (j < 16) begin
                if (out_q[j] !== a_bytes[j]) mism++;
            end else if (out_q[j] !== frm[j - 16]) begin
                mism++;
            end
        end
        total++;
        if (mism !== 0) begin
            bad++; $display("FAIL abort_data: got %0d mismatching bytes need 0", mism);
        end
        $display("abort: %0d eof_out, %0d bytes out", eof_cyc.size(), out_q.size());
    endtask

    task automatic test_reset_mid();
        build_good(64, 13);
        clear_mon();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b1, frm[i]);
        @(posedge lcl_clk);
        #1;
        valid_in = 1'b0;
        total++;
        if (valid_out !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got valid_out=%b need 1", valid_out);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({sof_out, valid_out, eof_out, frame_good, err_flags} !== 8'h00 || frame_len !== '0 || data_out !== 8'h00) begin
            bad++; $display("FAIL rstmid_outs: got ctl=%b flags=%b len=%0d data=%h need all 0",
                            {sof_out, valid_out, eof_out, frame_good}, err_flags, frame_len, data_out);
        end
        repeat (2) @(posedge lcl_clk);
        #1;
        reset_n = 1'b1;
        clear_mon();
        send_frame(1'b0);
        wait_eof(1, "rstmid");
        total++;
        if (eof_cyc.size() !== 1 || egood_q[0] !== 1'b1) begin
            bad++; $display("FAIL rstmid_next: got %0d eof_out, need 1 with frame_good=1", eof_cyc.size());
        end
`ifdef RX_FCS_STATS_EN
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        total++;
        if (good_frames !== 32'd1) begin
            bad++; $display("FAIL rstmid_stats: got good_frames=%0d need 1", good_frames);
        end
`endif
        $display("rstmid: %0d eof_out after reset", eof_cyc.size());
    endtask

`ifdef RX_FCS_STATS_EN
    task automatic test_stats();
        test_empty();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        total++;
        if (good_frames !== 32'd1 || crc_err_frames !== 32'd1 || len_err_frames !== 32'd1 || abort_frames !== 32'd0) begin
            bad++; $display("FAIL stats_count: got g=%0d c=%0d l=%0d a=%0d need 1/1/1/0",
                            good_frames, crc_err_frames, len_err_frames, abort_frames);
        end
        @(posedge lcl_clk);
        #1;
        clear_stats = 1'b1;
        @(posedge lcl_clk);
        #1;
        clear_stats = 1'b0;
        total++;
        if ({good_frames, crc_err_frames, len_err_frames, abort_frames} !== 128'h0) begin
            bad++; $display("FAIL stats_clear: got g=%0d c=%0d l=%0d a=%0d need 0",
                            good_frames, crc_err_frames, len_err_frames, abort_frames);
        end
        $display("stats: counters checked");
    endtask
`endif

    initial begin
        test_reset();
        test_good64();
        test_crc_err();
        test_length(1519, 4'b0100, "giant");
        test_length(1518, 4'b0000, "max");
        test_length(40, 4'b0010, "runt");
        test_empty();
        test_gaps();
        test_abort();
        test_reset_mid();
`ifdef RX_FCS_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
